// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the ALU issue stage:
//   XLEN        default datapath width
//   ALU_*       ALU opcodes carried on ALUControl
//   fwd_sel_t   per-operand forwarding source select
//   rd_hits()   "destination register rd writes source rs" test; x0 never hits
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // x0 is hard-wired to zero, so a write to it never produces a value worth
  // forwarding or waiting for.
  function automatic logic rd_hits(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational operand-source select and hazard detection for the entry
// held in the issue stage.
// Build option: ALU_ISSUE_FWD_EN
//   defined   - EX/MEM (non-load) and MEM/WB results are forwarded; only a
//               load in EX/MEM that writes rs1/rs2 stalls.
//   undefined - selects stay FWD_NONE; any EX/MEM or MEM/WB write to
//               rs1/rs2 stalls until the value reaches the held entry.
// Ports:
//   valid          held entry is valid
//   rs1, rs2       held source indices
//   ex_mem_rd      EX/MEM destination (0 = none)
//   ex_mem_is_load EX/MEM op is a load
//   mem_wb_rd      MEM/WB destination (0 = none)
//   sel_a, sel_b   operand source selects
//   hazard         held entry must not issue this cycle
// ---------------------------------------------------------------------------
module fwd_unit
  import riscv_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_is_load,
  input  logic [4:0] mem_wb_rd,
  output fwd_sel_t   sel_a,
  output fwd_sel_t   sel_b,
  output logic       hazard
);

`ifdef ALU_ISSUE_FWD_EN

  // Forwarding selects (EX/MEM is younger, so it wins) and load-use hazard.
  always_comb begin
    sel_a  = FWD_NONE;
    sel_b  = FWD_NONE;
    hazard = 1'b0;

    if (rd_hits(ex_mem_rd, rs1) && !ex_mem_is_load) begin
      sel_a = FWD_EXMEM;
    end else if (rd_hits(mem_wb_rd, rs1)) begin
      sel_a = FWD_MEMWB;
    end else begin
      sel_a = FWD_NONE;
    end

    if (rd_hits(ex_mem_rd, rs2) && !ex_mem_is_load) begin
      sel_b = FWD_EXMEM;
    end else if (rd_hits(mem_wb_rd, rs2)) begin
      sel_b = FWD_MEMWB;
    end else begin
      sel_b = FWD_NONE;
    end

    if (valid && ex_mem_is_load &&
        (rd_hits(ex_mem_rd, rs1) || rd_hits(ex_mem_rd, rs2))) begin
      hazard = 1'b1;
    end else begin
      hazard = 1'b0;
    end
  end

`else

  // Load type is irrelevant when every in-flight producer stalls.
  logic unused_s;
  assign unused_s = ex_mem_is_load;

  // No forwarding: any pending producer of rs1/rs2 stalls the entry.
  always_comb begin
    sel_a  = FWD_NONE;
    sel_b  = FWD_NONE;
    hazard = 1'b0;
    if (valid &&
        (rd_hits(ex_mem_rd, rs1) || rd_hits(ex_mem_rd, rs2) ||
         rd_hits(mem_wb_rd, rs1) || rd_hits(mem_wb_rd, rs2))) begin
      hazard = 1'b1;
    end else begin
      hazard = 1'b0;
    end
  end

`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// One-entry issue buffer between decode and the ALU. Captures a decoded op,
// resolves its operands (forwarding and MEM/WB snooping), stalls on hazards
// and hands the op to execute with a valid/ready handshake.
// Build option: ALU_ISSUE_FWD_EN (forwarding muxes present when defined).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   DValid/DReady     decode handshake
//   DRs1, DRs2, DRd   decoded register indices (DRd 0 = no writeback)
//   DRD1, DRD2        register-file read data
//   DImmExt, DALUSrc  immediate and SrcB select
//   DALUControl       ALU opcode
//   FlushE            squash held and offered op
//   ExMemRd/IsLoad/Result, MemWbRd/Result   downstream writeback info
//   EValid/EReady     execute handshake
//   SrcA, SrcB        resolved operands
//   ALUControl, RdE   held opcode and destination
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            DValid,
  output logic            DReady,
  input  logic [4:0]      DRs1,
  input  logic [4:0]      DRs2,
  input  logic [4:0]      DRd,
  input  logic [XLEN-1:0] DRD1,
  input  logic [XLEN-1:0] DRD2,
  input  logic [XLEN-1:0] DImmExt,
  input  logic            DALUSrc,
  input  logic [3:0]      DALUControl,
  input  logic            FlushE,
  input  logic [4:0]      ExMemRd,
  input  logic            ExMemIsLoad,
  input  logic [XLEN-1:0] ExMemResult,
  input  logic [4:0]      MemWbRd,
  input  logic [XLEN-1:0] MemWbResult,
  input  logic            EReady,
  output logic            EValid,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [3:0]      ALUControl,
  output logic [4:0]      RdE
);

  import riscv_pkg::*;

  logic            valid_r;
  logic [4:0]      rs1_r;
  logic [4:0]      rs2_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] rd1_r;
  logic [XLEN-1:0] rd2_r;
  logic [XLEN-1:0] imm_r;
  logic            alusrc_r;
  logic [3:0]      aluctl_r;

  fwd_sel_t        sel_a_s;
  fwd_sel_t        sel_b_s;
  logic            hazard_s;
  logic            evalid_s;
  logic            dready_s;
  logic            accept_s;
  logic            issue_s;
  logic [XLEN-1:0] opa_s;
  logic [XLEN-1:0] opb_s;

  fwd_unit u_fwd (
    .valid          (valid_r),
    .rs1            (rs1_r),
    .rs2            (rs2_r),
    .ex_mem_rd      (ExMemRd),
    .ex_mem_is_load (ExMemIsLoad),
    .mem_wb_rd      (MemWbRd),
    .sel_a          (sel_a_s),
    .sel_b          (sel_b_s),
    .hazard         (hazard_s)
  );

  // An accept in the same cycle as an issue refills the entry, so the stage
  // sustains one op per cycle.
  assign evalid_s = valid_r && !hazard_s;
  assign dready_s = !FlushE && (!valid_r || (evalid_s && EReady));
  assign accept_s = DValid && dready_s;
  assign issue_s  = evalid_s && EReady;

`ifdef ALU_ISSUE_FWD_EN

  // Operand source muxes driven by the forwarding selects.
  always_comb begin
    opa_s = rd1_r;
    opb_s = rd2_r;
    case (sel_a_s)
      FWD_EXMEM: opa_s = ExMemResult;
      FWD_MEMWB: opa_s = MemWbResult;
      default:   opa_s = rd1_r;
    endcase
    case (sel_b_s)
      FWD_EXMEM: opb_s = ExMemResult;
      FWD_MEMWB: opb_s = MemWbResult;
      default:   opb_s = rd2_r;
    endcase
  end

`else

  // Without forwarding the selects and EX/MEM data are not consumed.
  logic unused_s;
  assign unused_s = ^{sel_a_s, sel_b_s, ExMemResult};

  assign opa_s = rd1_r;
  assign opb_s = rd2_r;

`endif

  // Held entry: reset, flush, capture with MEM/WB bypass, or issue + snoop.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= 1'b0;
      rs1_r    <= 5'd0;
      rs2_r    <= 5'd0;
      rd_r     <= 5'd0;
      rd1_r    <= {XLEN{1'b0}};
      rd2_r    <= {XLEN{1'b0}};
      imm_r    <= {XLEN{1'b0}};
      alusrc_r <= 1'b0;
      aluctl_r <= 4'd0;
    end else if (FlushE) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r  <= 1'b1;
      rs1_r    <= DRs1;
      rs2_r    <= DRs2;
      rd_r     <= DRd;
      // The register file is written at the end of this cycle, so the
      // value read by decode may be stale; take the MEM/WB value instead.
      rd1_r    <= rd_hits(MemWbRd, DRs1) ? MemWbResult : DRD1;
      rd2_r    <= rd_hits(MemWbRd, DRs2) ? MemWbResult : DRD2;
      imm_r    <= DImmExt;
      alusrc_r <= DALUSrc;
      aluctl_r <= DALUControl;
    end else begin
      if (issue_s) begin
        valid_r <= 1'b0;
      end
      // Snoop retiring writes so a held op never loses a value that leaves
      // the pipeline while it waits.
      if (rd_hits(MemWbRd, rs1_r)) begin
        rd1_r <= MemWbResult;
      end
      if (rd_hits(MemWbRd, rs2_r)) begin
        rd2_r <= MemWbResult;
      end
    end
  end

  assign DReady     = dready_s;
  assign EValid     = evalid_s;
  assign SrcA       = opa_s;
  assign SrcB       = alusrc_r ? imm_r : opb_s;
  assign ALUControl = aluctl_r;
  assign RdE        = rd_r;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: XLEN, 64, datapath width.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 DValid  in  1  decode offers an op.
REQ-006 DReady  out  1  stage accepts the op this cycle.
REQ-007 DRs1  in  5  source register 1 index.
REQ-008 DRs2  in  5  source register 2 index.
REQ-009 DRd  in  5  destination index; 0 means no writeback.
REQ-010 DRD1  in  XLEN  register-file read data for rs1.
REQ-011 DRD2  in  XLEN  register-file read data for rs2.
REQ-012 DImmExt  in  XLEN  sign-extended immediate.
REQ-013 DALUSrc  in  1  1 selects immediate as SrcB.
REQ-014 DALUControl  in  4  ALU opcode.
REQ-015 FlushE  in  1  squash held op and any offered op.
REQ-016 ExMemRd  in  5  EX/MEM destination; 0 means none.
REQ-017 ExMemIsLoad  in  1  EX/MEM op is a load; result not yet available.
REQ-018 ExMemResult  in  XLEN  EX/MEM ALU result.
REQ-019 MemWbRd  in  5  MEM/WB destination; 0 means none.
REQ-020 MemWbResult  in  XLEN  MEM/WB writeback value.
REQ-021 EReady  in  1  downstream consumes the issued op.
REQ-022 EValid  out  1  SrcA/SrcB/ALUControl/RdE valid this cycle.
REQ-023 SrcA, SrcB  out  XLEN  ALU operands (signed).
REQ-024 ALUControl  out  4  registered opcode; RdE  out  5  registered destination.

Function
REQ-025 SHALL hold one entry (valid, rs1, rs2, rd, RD1, RD2, imm, ALUSrc, ALUControl); accept on DValid&&DReady; capture latency one cycle.
REQ-026 Hazard SHALL be asserted when held entry valid and (ExMemIsLoad && ExMemRd!=0 && ExMemRd matches rs1 or rs2).
REQ-027 EValid SHALL equal valid && !Hazard; DReady SHALL equal !FlushE && (!valid || (EValid && EReady)).
REQ-028 Entry SHALL clear valid on EValid&&EReady without new accept; simultaneous issue and accept SHALL replace the entry (full throughput).
REQ-029 SrcA SHALL be ExMemResult if ExMemRd==rs1!=0 and !ExMemIsLoad, else MemWbResult if MemWbRd==rs1!=0, else held RD1; EX/MEM has priority.
REQ-030 SrcB SHALL be held imm when ALUSrc=1, else rs2 forwarded per REQ-029 rules.
REQ-031 Snoop: every cycle MemWbRd!=0 matching held rs1/rs2 SHALL overwrite held RD1/RD2; on accept the same match SHALL bypass into captured DRD1/DRD2.
REQ-032 FlushE SHALL clear valid next edge and discard the offered op; flush wins over issue and accept.
REQ-033 x0 SHALL never forward or cause hazard.

Reset
REQ-034 reset SHALL clear valid and all held fields to 0: EValid=0, SrcA=SrcB=0, ALUControl=0, RdE=0, DReady=1 after release; reset mid-stall discards the op.

Configuration
REQ-035 Macro ALU_ISSUE_FWD_EN defined: forwarding per REQ-029/030, Hazard per REQ-026.
REQ-036 Undefined: no forwarding muxes; Hazard also asserts on any ExMemRd or MemWbRd match (!=0); operands come from held RD1/RD2 only, snoop per REQ-031 still active.

Structure
REQ-037 Package riscv_pkg SHALL hold XLEN, ALU opcodes (AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110) and the forwarding-select enum (FWD_NONE, FWD_EXMEM, FWD_MEMWB).
REQ-038 One sub-module fwd_unit SHALL compute per-operand select and Hazard combinationally.

Verification
REQ-039 Back-to-back ADD ops, EReady=1 -> EValid every cycle, SrcA/SrcB equal captured values, one-cycle latency.
REQ-040 Held rs1=5, ExMemRd=5, ExMemResult=0x10, MemWbRd=5, MemWbResult=0x20 -> SrcA=0x10 (FWD_EN), EValid=0 (no FWD_EN).
REQ-041 ExMemIsLoad=1, ExMemRd=rs2=7, one cycle -> EValid=0, DReady=0; next cycle MemWbRd=7, MemWbResult=0x99 -> EValid=1, SrcB=0x99.
REQ-042 FlushE with DValid=1 and valid entry -> next cycle EValid=0, offered op not captured.
REQ-043 Rs1=0 with ExMemRd=0, ExMemIsLoad=1 -> no stall, SrcA=DRD1; reset asserted mid-stall -> EValid=0, all outputs 0.
